// File: rtl/nios_dbg_scan_slave.sv
// Debug scan slave for the Nios II on-chip debug path, clocked entirely by clk.
// Optional DBG_SCAN_ACK_EN build holds action strobes until acknowledged and flags overruns.
module nios_dbg_scan_slave #(
    parameter int DR_W   = 38,
    parameter int IR_W   = 2,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tck_en,
    input  logic                     tdi,
    input  logic                     vs_cdr,
    input  logic                     vs_sdr,
    input  logic                     vs_e1dr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [NUM_CH*DR_W-1:0]   cap_data,
    input  logic [NUM_CH-1:0]        act_ack,
    output logic                     tdo,
    output logic [DR_W-1:0]          jdo,
    output logic [IR_W-1:0]          ir_cur,
    output logic [NUM_CH-1:0]        take_action,
    output logic [NUM_CH-1:0]        take_no_action,
    output logic                     err_len,
    output logic                     err_ovr
);

    localparam int BCW = $clog2(DR_W + 2);
    localparam logic [BCW-1:0] CNT_FULL = BCW'(DR_W);
    localparam logic [BCW-1:0] CNT_SAT  = BCW'(DR_W + 1);

    logic [DR_W-1:0]   sr_reg, sr_next;
    logic [BCW-1:0]    bitcnt_reg, bitcnt_next;
    logic [IR_W-1:0]   ir_reg, ir_next;
    logic [DR_W-1:0]   jdo_reg, jdo_next;
    logic              tdo_reg, tdo_next;
    logic [NUM_CH-1:0] ta_reg, ta_next;
    logic [NUM_CH-1:0] tna_reg, tna_next;
    logic              err_len_reg, err_len_next;
    logic              err_ovr_reg, err_ovr_next;

    logic [NUM_CH-1:0] cap_hit;
    logic [NUM_CH-1:0] cur_hit;
    logic [DR_W-1:0]   cap_masked [NUM_CH];
    logic [DR_W-1:0]   cap_word;
    logic              cur_valid;
    logic              ack_done;
    logic              pending;

    // Per-channel decode; an out-of-range instruction matches nothing, so it captures zero.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign cap_hit[gi]    = (ir_in == IR_W'(gi));
            assign cur_hit[gi]    = (ir_reg == IR_W'(gi));
            assign cap_masked[gi] = cap_hit[gi] ? cap_data[gi*DR_W +: DR_W] : '0;
        end
    endgenerate

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cap_word = cap_word | cap_masked[i];
        end
    end

    assign cur_valid = |cur_hit;

`ifdef DBG_SCAN_ACK_EN
    assign ack_done = |((ta_reg | tna_reg) & act_ack);
    assign pending  = (|(ta_reg | tna_reg)) && !ack_done;
`else
    logic unused_ack;
    // Without the handshake every strobe retires after a single cycle.
    assign ack_done   = 1'b1;
    assign pending    = 1'b0;
    assign unused_ack = ^act_ack;
`endif

    always_comb begin
        sr_next      = sr_reg;
        bitcnt_next  = bitcnt_reg;
        ir_next      = ir_reg;
        jdo_next     = jdo_reg;
        tdo_next     = tdo_reg;
        ta_next      = ta_reg;
        tna_next     = tna_reg;
        err_len_next = err_len_reg;
        err_ovr_next = err_ovr_reg;
        if (ack_done) begin
            ta_next  = '0;
            tna_next = '0;
        end
        if (tck_en) begin
            if (vs_cdr) begin
                ir_next     = ir_in;
                sr_next     = cap_word;
                bitcnt_next = '0;
                tdo_next    = cap_word[0];
            end else if (vs_sdr) begin
                sr_next  = {tdi, sr_reg[DR_W-1:1]};
                tdo_next = sr_reg[1];
                if (bitcnt_reg != CNT_SAT) begin
                    bitcnt_next = bitcnt_reg + BCW'(1);
                end
            end else if (vs_e1dr) begin
                if (pending) begin
                    err_ovr_next = 1'b1;
                end else begin
                    jdo_next = sr_reg;
                    if (cur_valid) begin
                        if (bitcnt_reg == CNT_FULL) begin
                            ta_next = cur_hit;
                        end else begin
                            tna_next     = cur_hit;
                            err_len_next = 1'b1;
                        end
                    end
                end
            end else if (vs_uir) begin
                ir_next = ir_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_reg      <= '0;
            bitcnt_reg  <= '0;
            ir_reg      <= '0;
            jdo_reg     <= '0;
            tdo_reg     <= 1'b0;
            ta_reg      <= '0;
            tna_reg     <= '0;
            err_len_reg <= 1'b0;
            err_ovr_reg <= 1'b0;
        end else begin
            sr_reg      <= sr_next;
            bitcnt_reg  <= bitcnt_next;
            ir_reg      <= ir_next;
            jdo_reg     <= jdo_next;
            tdo_reg     <= tdo_next;
            ta_reg      <= ta_next;
            tna_reg     <= tna_next;
            err_len_reg <= err_len_next;
            err_ovr_reg <= err_ovr_next;
        end
    end

    assign tdo            = tdo_reg;
    assign jdo            = jdo_reg;
    assign ir_cur         = ir_reg;
    assign take_action    = ta_reg;
    assign take_no_action = tna_reg;
    assign err_len        = err_len_reg;
    assign err_ovr        = err_ovr_reg;

endmodule

// File: tb/tb_nios_dbg_scan_slave.sv
// Scoreboard bench for nios_dbg_scan_slave: stimulus pushes expectations, a monitor checks them.
// Define DBG_SCAN_ACK_EN for both files to also exercise the acknowledge handshake.
module tb_nios_dbg_scan_slave;

    localparam int DR_W   = 38;
    localparam int IR_W   = 2;
    localparam int NUM_CH = 3;

    localparam logic [37:0] CAP0 = 38'h0_1234_5678;
    localparam logic [37:0] CAP1 = 38'h2_5A5A_5A5A;
    localparam logic [37:0] CAP2 = 38'h2_C3C3_C3C1;
    localparam logic [37:0] ONES = 38'h3F_FFFF_FFFF;
    localparam logic [37:0] W_C  = 38'h15_A5A5_1234;
    localparam logic [37:0] W_D  = 38'h2A_0F0F_F0F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n = 1'b0;
    logic                   tck_en = 1'b0;
    logic                   tdi = 1'b0;
    logic                   vs_cdr = 1'b0;
    logic                   vs_sdr = 1'b0;
    logic                   vs_e1dr = 1'b0;
    logic                   vs_uir = 1'b0;
    logic [IR_W-1:0]        ir_in = '0;
    logic [NUM_CH*DR_W-1:0] cap_data;
    logic [NUM_CH-1:0]      act_ack = '1;
    logic                   tdo;
    logic [DR_W-1:0]        jdo;
    logic [IR_W-1:0]        ir_cur;
    logic [NUM_CH-1:0]      take_action;
    logic [NUM_CH-1:0]      take_no_action;
    logic                   err_len;
    logic                   err_ovr;

    assign cap_data = {CAP2, CAP1, CAP0};

    nios_dbg_scan_slave #(.DR_W(DR_W), .IR_W(IR_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset_n(reset_n), .tck_en(tck_en), .tdi(tdi),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr), .vs_uir(vs_uir),
        .ir_in(ir_in), .cap_data(cap_data), .act_ack(act_ack),
        .tdo(tdo), .jdo(jdo), .ir_cur(ir_cur),
        .take_action(take_action), .take_no_action(take_no_action),
        .err_len(err_len), .err_ovr(err_ovr)
    );

    typedef struct {
        int          stamp;
        bit          full;
        logic        tdo;
        logic [37:0] jdo;
        logic [1:0]  ir;
        logic [2:0]  ta;
        logic [2:0]  tna;
        logic        el;
        logic        eo;
    } chk_t;

    typedef struct {
        logic [2:0]  ta;
        logic [2:0]  tna;
        logic [37:0] jdo;
        logic        el;
    } stb_t;

    chk_t chk_q[$];
    stb_t stb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_stb = 0;
    logic [37:0] m_sr = '0;
    logic        m_eo = 1'b0;
    logic [2:0]  ack_s = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ack_s <= act_ack;
    end

    // Monitor: stamped checks are due at a given cycle; strobe checks fire when the DUT raises one.
    logic [2:0] prev_stb = '0;
    always @(negedge clk) begin
        chk_t c;
        stb_t s;
        logic [2:0] stb_now;
        logic new_ev;
        while (chk_q.size() > 0 && chk_q[0].stamp <= cyc) begin
            c = chk_q.pop_front();
            vectors++;
            if (c.stamp != cyc) begin
                miscompares++;
                $display("FAIL late_check: due cycle %0d, seen at cycle %0d", c.stamp, cyc);
            end else if (!c.full) begin
                if (tdo !== c.tdo) begin
                    miscompares++;
                    $display("FAIL tdo @%0d: got %b want %b", cyc, tdo, c.tdo);
                end
            end else if (tdo !== c.tdo || jdo !== c.jdo || ir_cur !== c.ir || take_action !== c.ta ||
                         take_no_action !== c.tna || err_len !== c.el || err_ovr !== c.eo) begin
                miscompares++;
                $display("FAIL state @%0d: got tdo=%b jdo=%h ir=%0d ta=%b tna=%b el=%b eo=%b want tdo=%b jdo=%h ir=%0d ta=%b tna=%b el=%b eo=%b",
                         cyc, tdo, jdo, ir_cur, take_action, take_no_action, err_len, err_ovr,
                         c.tdo, c.jdo, c.ir, c.ta, c.tna, c.el, c.eo);
            end
        end
        stb_now = take_action | take_no_action;
`ifdef DBG_SCAN_ACK_EN
        new_ev = (stb_now != 3'b000) && (prev_stb == 3'b000 || (prev_stb & ack_s) != 3'b000);
`else
        new_ev = (stb_now != 3'b000);
`endif
        if (new_ev) begin
            vectors++;
            n_stb++;
            $display("strobe %0d @%0d: ta=%b tna=%b jdo=%h el=%b", n_stb, cyc, take_action, take_no_action, jdo, err_len);
            if (stb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe @%0d: got ta=%b tna=%b want none", cyc, take_action, take_no_action);
            end else begin
                s = stb_q.pop_front();
                if (take_action !== s.ta || take_no_action !== s.tna || jdo !== s.jdo || err_len !== s.el) begin
                    miscompares++;
                    $display("FAIL strobe @%0d: got ta=%b tna=%b jdo=%h el=%b want ta=%b tna=%b jdo=%h el=%b",
                             cyc, take_action, take_no_action, jdo, err_len, s.ta, s.tna, s.jdo, s.el);
                end
            end
        end
        prev_stb = stb_now;
    end

    task automatic step(input logic en, input logic cdr, input logic sdr, input logic e1,
                        input logic uir, input logic d, input logic [1:0] ir,
                        input logic [2:0] ack = 3'b111);
        @(negedge clk);
        reset_n = 1'b1;
        tck_en  = en;
        vs_cdr  = cdr;
        vs_sdr  = sdr;
        vs_e1dr = e1;
        vs_uir  = uir;
        tdi     = d;
        ir_in   = ir;
        act_ack = ack;
    endtask

    task automatic push_tdo(input logic v);
        chk_t c;
        c = '{stamp: cyc + 1, full: 1'b0, tdo: v, jdo: '0, ir: '0, ta: '0, tna: '0, el: 1'b0, eo: 1'b0};
        chk_q.push_back(c);
    endtask

    task automatic push_all(input logic v, input logic [37:0] j, input logic [1:0] ir,
                            input logic [2:0] ta, input logic [2:0] tna, input logic el, input logic eo);
        chk_t c;
        c = '{stamp: cyc + 1, full: 1'b1, tdo: v, jdo: j, ir: ir, ta: ta, tna: tna, el: el, eo: eo};
        chk_q.push_back(c);
    endtask

    task automatic push_stb(input logic [2:0] ta, input logic [2:0] tna, input logic [37:0] j, input logic el);
        stb_t s;
        s = '{ta: ta, tna: tna, jdo: j, el: el};
        stb_q.push_back(s);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        reset_n = 1'b0;
        tck_en  = 1'b0;
        vs_cdr  = 1'b0;
        vs_sdr  = 1'b0;
        vs_e1dr = 1'b0;
        vs_uir  = 1'b0;
        tdi     = 1'b0;
        act_ack = '1;
        m_sr    = '0;
        push_all(1'b0, '0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    // Capture, nshift shifts of din (LSB first), exit1, then one idle cycle.
    task automatic scan(input logic [1:0] ir, input int nshift, input logic [37:0] din,
                        input logic [37:0] cap, input logic [2:0] ta, input logic [2:0] tna,
                        input logic [37:0] j, input logic el, input logic [2:0] ack = 3'b111);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ir, ack);
        m_sr = cap;
        push_tdo(m_sr[0]);
        for (int k = 0; k < nshift; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, din[k], ir, ack);
            m_sr = {din[k], m_sr[37:1]};
            push_tdo(m_sr[0]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ir, ack);
        if ((ta | tna) != 3'b000) push_stb(ta, tna, j, el);
        else push_all(m_sr[0], j, ir, 3'b000, 3'b000, el, m_eo);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ir, ack);
    endtask

    initial begin
        rst_cycle();
        rst_cycle();

        // full-length scan on channel 1, then a short one, then a correct one (err_len sticky)
        scan(2'd1, 38, ONES, CAP1, 3'b010, 3'b000, ONES, 1'b0);
        scan(2'd1, 37, ONES, CAP1, 3'b000, 3'b010, 38'h3F_FFFF_FFFE, 1'b1);
        scan(2'd0, 38, W_C, CAP0, 3'b001, 3'b000, W_C, 1'b1);
        // unimplemented instruction: captures zero, jdo updates, no strobe
        scan(2'd3, 38, W_D, 38'h0, 3'b000, 3'b000, W_D, 1'b1);

        // cdr beats sdr; sdr without tck_en does nothing
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        m_sr = CAP2;
        push_tdo(m_sr[0]);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        push_tdo(m_sr[0]);
        for (int k = 0; k < 38; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
            m_sr = {1'b0, m_sr[37:1]};
            push_tdo(m_sr[0]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        push_stb(3'b100, 3'b000, 38'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);

        // update-IR alone, then e1dr beating uir in the same cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        push_all(m_sr[0], 38'h0, 2'd1, 3'b000, 3'b000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        push_stb(3'b010, 3'b000, 38'h0, 1'b1);
        push_all(m_sr[0], 38'h0, 2'd1, 3'b010, 3'b000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);

        // reset in the middle of a scan, then a normal scan
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        m_sr = CAP1;
        push_tdo(m_sr[0]);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
            m_sr = {1'b1, m_sr[37:1]};
            push_tdo(m_sr[0]);
        end
        rst_cycle();
        scan(2'd1, 38, ONES, CAP1, 3'b010, 3'b000, ONES, 1'b0);

`ifdef DBG_SCAN_ACK_EN
        // strobe held until ack; a second e1dr while pending is dropped and flags overrun
        scan(2'd0, 38, W_C, CAP0, 3'b001, 3'b000, W_C, 1'b0, 3'b000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'b000);
        m_sr = CAP2;
        push_tdo(m_sr[0]);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 3'b000);
        push_all(m_sr[0], W_C, 2'd2, 3'b001, 3'b000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'b000);
        push_all(m_sr[0], W_C, 2'd2, 3'b001, 3'b000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'b001);
        push_all(m_sr[0], W_C, 2'd2, 3'b000, 3'b000, 1'b0, 1'b1);
        m_eo = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
`endif

        repeat (8) @(negedge clk);
        #1;
        vectors++;
        if (stb_q.size() != 0) begin
            miscompares++;
            $display("FAIL strobe_timeout: %0d expected strobes never seen, want 0", stb_q.size());
        end
        vectors++;
        if (chk_q.size() != 0) begin
            miscompares++;
            $display("FAIL check_timeout: %0d stamped checks pending, want 0", chk_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
